mmio_bus_arbiter: RTL

- Shares the single MMIO bus (cs/read/write/addr/write_data/read_data) feeding the slot decoder between NUM_MASTERS requesters, e.g. the MCS CPU bridge and a DMA/debug master.
- Round-robin arbitration with one bus transaction per grant.
- Fixed 3-cycle req-to-ack sequence per transaction.
- Sits between the masters and the MMIO controller, at the top of the MMIO subsystem.

---
 rtl/mmio_bus_arbiter_pkg.sv | 26 ++
 rtl/mmio_bus_arbiter_if.sv | 34 +++
 rtl/mmio_bus_arbiter_rr_pick.sv | 50 +++++
 rtl/mmio_bus_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mmio_bus_arbiter_pkg.sv
// Package mmio_arb_pkg: shared types and constants for the MMIO bus arbiter.
//   state_t      : arbiter FSM states (IDLE, ISSUE, RESP)
//   MMIO_ADDR_W  : default MMIO address width
//   MMIO_DATA_W  : default MMIO data width
//   grant_w()    : width of a master index for a given master count
package mmio_arb_pkg;

  localparam int unsigned MMIO_ADDR_W = 21;
  localparam int unsigned MMIO_DATA_W = 32;

  // Legacy state encodings kept as named constants; the enum reuses them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    RESP  = ST_RESP
  } state_t;

  function automatic int unsigned grant_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// Interface mmio_bus_arbiter_if: requester-side handshake of the MMIO arbiter.
//   m_req    : per-master request, held until that master's ack
//   m_write  : per-master direction (1 = write)
//   m_addr   : per-master address
//   m_wdata  : per-master write data
//   m_ack    : one-cycle completion pulse to the granted master
//   m_rdata  : shared read data, valid in the ack cycle
// Modports: master (requester view), slave (arbiter view).
interface mmio_bus_arbiter_if
  import mmio_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = MMIO_ADDR_W,
  parameter int unsigned DATA_W      = MMIO_DATA_W
);

  logic [NUM_MASTERS-1:0]             m_req;
  logic [NUM_MASTERS-1:0]             m_write;
  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]             m_ack;
  logic [DATA_W-1:0]                  m_rdata;

  modport master (
    output m_req, m_write, m_addr, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_write, m_addr, m_wdata,
    output m_ack, m_rdata
  );

endinterface

// File: rtl/mmio_bus_arbiter_rr_pick.sv
// mmio_rr_pick: combinational requester picker for the MMIO arbiter.
//   req_i   : request vector
//   last_i  : index of the last granted master
//   valid_o : any request present
//   idx_o   : chosen master index
// Default: rotating priority starting at last_i+1 with wrap-around.
// MMIO_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins; last_i ignored.
module mmio_rr_pick
  import mmio_arb_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = grant_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [31:0] cand;

`ifdef MMIO_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;

  // Scan from highest to lowest index so the lowest requester is assigned last.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = N; k > 0; k--) begin
      cand = k - 1;
      if (req_i[cand[IDX_W-1:0]]) idx_o = cand[IDX_W-1:0];
    end
  end
`else
  // Scan from lowest to highest priority so the nearest requester after
  // last_i is assigned last and therefore wins.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = N; k > 0; k--) begin
      cand = (32'(last_i) + k) % N;
      if (req_i[cand[IDX_W-1:0]]) idx_o = cand[IDX_W-1:0];
    end
  end
`endif

endmodule

// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter: shares one MMIO bus between NUM_MASTERS requesters,
// one transaction per grant, fixed IDLE -> ISSUE -> RESP sequence.
//   clk, reset_n        : clock, asynchronous active-low reset
//   mif (slave modport) : per-master req/write/addr/wdata in, ack/rdata out
//   mmio_cs/read/write  : bus chip select and strobes (ISSUE only)
//   mmio_addr/write_data: registered bus address and write data
//   mmio_read_data      : bus read data, captured at the end of ISSUE
//   busy                : high in ISSUE and RESP
//   grant_id            : current or last granted master
// Option macro: MMIO_ARB_FIXED_PRIO_EN selects fixed priority in the picker.
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 2,
  parameter  int unsigned ADDR_W      = MMIO_ADDR_W,
  parameter  int unsigned DATA_W      = MMIO_DATA_W,
  localparam int unsigned GW          = grant_w(NUM_MASTERS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mmio_bus_arbiter_if.slave    mif,
  output logic                 mmio_cs,
  output logic                 mmio_read,
  output logic                 mmio_write,
  output logic [ADDR_W-1:0]    mmio_addr,
  output logic [DATA_W-1:0]    mmio_write_data,
  input  logic [DATA_W-1:0]    mmio_read_data,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  state_t            state_q, state_d;
  logic [GW-1:0]     last_q, last_d;
  logic [GW-1:0]     gid_q, gid_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              pick_valid;
  logic [GW-1:0]     pick_idx;

  mmio_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (GW)
  ) u_pick (
    .req_i   (mif.m_req),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Request fields are latched at grant time, so a master dropping its
  // request after being granted cannot disturb the transaction, and the
  // bus address/data only change when a new ISSUE begins.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gid_d   = pick_idx;
          last_d  = pick_idx;
          wr_d    = mif.m_write[pick_idx];
          addr_d  = mif.m_addr[pick_idx];
          wdata_d = mif.m_wdata[pick_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!wr_q) rdata_d = mmio_read_data;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= GW'(NUM_MASTERS - 1);
      gid_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode straight from the state register so an async reset
  // removes them without waiting for a clock.
  assign mmio_cs         = (state_q == ISSUE);
  assign mmio_read       = mmio_cs & ~wr_q;
  assign mmio_write      = mmio_cs &  wr_q;
  assign mmio_addr       = addr_q;
  assign mmio_write_data = wdata_q;
  assign busy            = (state_q != IDLE);
  assign grant_id        = gid_q;
  assign mif.m_rdata     = rdata_q;

  always_comb begin
    mif.m_ack = '0;
    if (state_q == RESP) mif.m_ack[gid_q] = 1'b1;
  end

endmodule
